// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the bus-based CPU control path: opcodes, ALU function
// codes, sequencer states, IR field positions and small opcode helpers.
package cpu_defs_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_HALT  = 2'd3;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_IN   = 5'd18;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;
  localparam logic [3:0] ALU_INC = 4'd12;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:          alu_code = ALU_SUB;
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_OR,  OP_ORI:  alu_code = ALU_OR;
      OP_SHR:          alu_code = ALU_SHR;
      OP_SHL:          alu_code = ALU_SHL;
      OP_ROR:          alu_code = ALU_ROR;
      OP_ROL:          alu_code = ALU_ROL;
      OP_MUL:          alu_code = ALU_MUL;
      OP_DIV:          alu_code = ALU_DIV;
      OP_NEG:          alu_code = ALU_NEG;
      OP_NOT:          alu_code = ALU_NOT;
      default:         alu_code = ALU_ADD;
    endcase
  endfunction

  // Final EXEC step of each instruction class; only meaningful for opcodes that enter EXEC.
  function automatic logic [2:0] exec_last(input logic [4:0] op);
    if (op == OP_LD || op == OP_ST)                  exec_last = 3'd7;
    else if (op == OP_MUL || op == OP_DIV)           exec_last = 3'd6;
    else if (op == OP_LDI || (op >= OP_ADD && op <= OP_ORI)) exec_last = 3'd5;
    else if (op == OP_NEG || op == OP_NOT)           exec_last = 3'd4;
    else                                             exec_last = 3'd3;
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    is_legal = (op <= OP_IN) || (op >= OP_MFHI && op <= OP_HALT);
  endfunction

endpackage

// File: rtl/reg_onehot_decode.sv
// Turns a 4-bit register field into a one-hot GPR select, all zero when disabled.
module reg_onehot_decode #(
  parameter int NREG = 16
) (
  input  logic [3:0]      field,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  assign onehot = en ? (NREG'(1) << field) : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: walks each instruction through fetch T0..T2 and execute
// T3..T7, decoding datapath strobes from the registered state, step and IR.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int ALU_OPW = 4
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               run,
  input  logic [31:0]        ir,
  input  logic               mem_ready,
  output logic [NREG-1:0]    Rin,
  output logic [NREG-1:0]    Rout,
  output logic               PCin,
  output logic               PCout,
  output logic               IRin,
  output logic               MARin,
  output logic               MDRin,
  output logic               MDRout,
  output logic               Yin,
  output logic               Zin,
  output logic               Zhighout,
  output logic               Zlowout,
  output logic               HIin,
  output logic               HIout,
  output logic               LOin,
  output logic               LOout,
  output logic               Cout,
  output logic               InPortout,
  output logic               Read,
  output logic               Write,
  output logic [ALU_OPW-1:0] alu_op,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op
);

  state_t     state, state_nxt;
  logic [2:0] step, step_nxt;
  logic       held, illegal_q;
  logic [4:0] op;
  logic [3:0] ra, rb, rc, rout_sel, alu_sel;
  logic       rin_en, rout_en, wait_step, fetch, exec;
  logic       is_rr, is_imm, is_md, is_un, is_ldst;
  logic       ir_unused;

  assign op = ir[OP_MSB:OP_LSB];
  assign ra = ir[RA_MSB:RA_LSB];
  assign rb = ir[RB_MSB:RB_LSB];
  assign rc = ir[RC_MSB:RC_LSB];
  assign ir_unused = ^ir[RC_LSB-1:0];

  assign fetch   = (state == ST_FETCH);
  assign exec    = (state == ST_EXEC);
  assign is_rr   = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_md   = (op == OP_MUL) || (op == OP_DIV);
  assign is_un   = (op == OP_NEG) || (op == OP_NOT);
  assign is_ldst = (op <= OP_ST);

  // Steps that stall on the memory handshake.
  assign wait_step = (fetch && step == 3'd1) ||
                     (exec && step == 3'd6 && op == OP_LD) ||
                     (exec && step == 3'd7 && op == OP_ST);

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_FETCH;
          step_nxt  = 3'd0;
        end
      end
      ST_FETCH: begin
        if (step == 3'd0) begin
          step_nxt = 3'd1;
        end else if (step == 3'd1) begin
          if (mem_ready) step_nxt = 3'd2;
        end else if (op == OP_HALT) begin
          state_nxt = ST_HALT;
        end else if (op == OP_NOP || !is_legal(op)) begin
          state_nxt = run ? ST_FETCH : ST_IDLE;
          step_nxt  = 3'd0;
        end else begin
          state_nxt = ST_EXEC;
          step_nxt  = 3'd3;
        end
      end
      ST_EXEC: begin
        if (wait_step && !mem_ready) begin
          step_nxt = step;
        end else if (step == exec_last(op)) begin
          state_nxt = run ? ST_FETCH : ST_IDLE;
          step_nxt  = 3'd0;
        end else begin
          step_nxt = step + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= ST_IDLE;
      step      <= 3'd0;
      held      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      held      <= wait_step && !mem_ready;
      illegal_q <= fetch && (step == 3'd2) && !is_legal(op);
    end
  end

  // held marks repeat cycles of a wait step, so PCin only fires on the first T1 cycle.
  always_comb begin
    PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0; Cout = 1'b0;
    InPortout = 1'b0; Read = 1'b0; Write = 1'b0; alu_sel = ALU_ADD;
    rin_en = 1'b0; rout_en = 1'b0; rout_sel = rb;
    if (fetch) begin
      case (step)
        3'd0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; alu_sel = ALU_INC; end
        3'd1: begin Zlowout = 1'b1; PCin = !held; Read = 1'b1; MDRin = 1'b1; end
        default: begin MDRout = 1'b1; IRin = 1'b1; end
      endcase
    end else if (exec) begin
      case (step)
        3'd3: begin
          if (is_rr || is_imm || is_md || is_ldst) begin rout_en = 1'b1; Yin = 1'b1; end
          if (is_un) begin rout_en = 1'b1; Zin = 1'b1; alu_sel = alu_code(op); end
          if (op == OP_MFHI) begin HIout = 1'b1; rin_en = 1'b1; end
          if (op == OP_MFLO) begin LOout = 1'b1; rin_en = 1'b1; end
          if (op == OP_IN)   begin InPortout = 1'b1; rin_en = 1'b1; end
        end
        3'd4: begin
          if (is_rr || is_md) begin rout_en = 1'b1; rout_sel = rc; end
          if (is_imm || is_ldst) Cout = 1'b1;
          if (is_rr || is_md || is_imm || is_ldst) begin Zin = 1'b1; alu_sel = alu_code(op); end
          if (is_un) begin Zlowout = 1'b1; rin_en = 1'b1; end
        end
        3'd5: begin
          Zlowout = 1'b1;
          if (is_md) LOin = 1'b1;
          else if (op == OP_LD || op == OP_ST) MARin = 1'b1;
          else rin_en = 1'b1;
        end
        3'd6: begin
          if (is_md) begin Zhighout = 1'b1; HIin = 1'b1; end
          if (op == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
          if (op == OP_ST) begin rout_en = 1'b1; rout_sel = ra; MDRin = 1'b1; end
        end
        default: begin
          if (op == OP_LD) begin MDRout = 1'b1; rin_en = 1'b1; end
          if (op == OP_ST) Write = 1'b1;
        end
      endcase
    end
  end

  assign alu_op     = ALU_OPW'(alu_sel);
  assign busy       = fetch || exec;
  assign halted     = (state == ST_HALT);
  assign illegal_op = illegal_q;

  reg_onehot_decode #(.NREG(NREG)) u_rin_dec (
    .field  (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_onehot_decode #(.NREG(NREG)) u_rout_dec (
    .field  (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit bus-based datapath: 16 GPRs, PC, IR, MAR, MDR, Y, Z (high/low), HI and LO.
- Steps each instruction through fetch and execute micro-steps (T0..T7) and emits the per-cycle register in/out strobes, ALU opcode and memory Read/Write.
- Inserts wait states on a memory-ready handshake.
- Sits between the instruction register contents and the datapath control inputs.

Parameters:
- NREG, 16, number of general-purpose registers; one-hot width of Rin/Rout.
- ALU_OPW, 4, width of the alu_op output.

Ports:
- Clock in 1: rising-edge clock.
- Clear in 1: asynchronous active-low reset.
- run in 1: level; 1 permits fetching new instructions.
- ir in 32: current IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- mem_ready in 1: memory completed the current Read/Write this cycle.
- Rin out NREG: one-hot GPR load enables.
- Rout out NREG: one-hot GPR bus drive enables.
- PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout, InPortout: out 1 each; datapath strobes.
- Read, Write out 1: memory strobes; MDR input mux selects memory when Read=1, else bus.
- alu_op out ALU_OPW: ALU function, valid in any cycle with Zin=1.
- busy out 1: instruction in progress.
- halted out 1: HALT state.
- illegal_op out 1: one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (Clear=0, async): state IDLE, step=0. All outputs 0, alu_op=0.
- States:
  - IDLE: if run=1, go to FETCH T0 next cycle.
  - FETCH T0..T2, then EXEC T3..T7.
  - After the last EXEC step, go to FETCH T0 if run=1, else IDLE.
  - HALT is left only by Clear.
- Outputs are decoded combinationally from the registered state, step and ir. At most one bus driver (*out, Rout, Cout, InPortout) is 1 per cycle; this is a bench assertion.
- Fetch:
  - T0: PCout, MARin, Zin, alu_op=INC.
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 with Read and MDRin=1 until mem_ready=1. PCin pulses only on the first T1 cycle.
  - T2: MDRout, IRin.
- Execute. The ir fields are sampled during EXEC, so IR must be stable after T2.
- ALU reg-reg (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin, alu_op.
  - T5: Zlowout, Rin[Ra].
- Immediate (addi 01011, andi 01100, ori 01101): as reg-reg, but T4 drives Cout instead of Rout[Rc].
- mul 01110, div 01111:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- neg 10000, not 10001:
  - T3: Rout[Rb], Zin, alu_op.
  - T4: Zlowout, Rin[Ra].
- mfhi 11000: T3 HIout, Rin[Ra]. mflo 11001: T3 LOout, Rin[Ra]. in 10010: T3 InPortout, Rin[Ra].
- Address phase for ld 00000, ldi 00001, st 00010:
  - T3: Rout[Rb], Yin.
  - T4: Cout, Zin, alu_op=ADD.
- ld:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait for mem_ready.
  - T7: MDRout, Rin[Ra].
- ldi: T5 Zlowout, Rin[Ra].
- st:
  - T5: Zlowout, MARin.
  - T6: Rout[Ra], MDRin.
  - T7: Write; wait for mem_ready.
- nop 11010: no EXEC steps; return to fetch after T2.
- halt 11011: HALT after T2; halted=1, busy=0.
- Any other opcode: illegal_op=1 during the cycle after T2, then treated as nop.
- mem_ready is ignored outside wait steps. A mem_ready asserted in the same cycle Read/Write first rises completes that step with zero wait.
- run falling mid-instruction: the current instruction completes, then IDLE.
- Clear mid-wait: immediate IDLE, Read/Write drop asynchronously.
- busy=1 in FETCH and EXEC, 0 in IDLE and HALT.
- alu_op encoding: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, MUL 8, DIV 9, NEG 10, NOT 11, INC 12.

Decomposition:
- Shared package cpu_defs_pkg holds the opcode constants, alu_op encodings, state enum (IDLE, FETCH, EXEC, HALT) and IR field bit positions.
- One sub-module, reg_onehot_decode: a 4-bit field plus enable, producing a one-hot NREG vector. Instantiated for Rin and Rout.

Test Plan:
- Reset then run=1, mem_ready tied 1, ir=0x19890000 (add R3,R1,R2): T0 PCout/MARin/Zin/alu_op=12; T1 PCin/Read; T2 IRin; T3 Rout=0x0002 with Yin; T4 Rout=0x0004 with alu_op=0; T5 Rin=0x0008. Fetch restarts on cycle 7.
- mem_ready held 0 for 3 cycles in T1: Read and MDRin stay 1 for 4 cycles, PCin pulses once, IRin asserts on the cycle after mem_ready.
- ir mul R0,R5,R6 (0x70000000 | Rb=5 | Rc=6): LOin at T5, HIin at T6, Zlowout/Zhighout correspond; 7 cycles total.
- st R2,0(R4) with a 2-cycle write wait: MARin at T5, Rout=0x0004 with MDRin at T6, Write held 3 cycles, no Read during the execute phase.
- Opcode 11111: illegal_op pulses once, no Rin asserted, next fetch follows. halt opcode: halted=1, all strobes 0 for 20 cycles despite run=1.
- Clear asserted while in ld T6 waiting: all outputs 0 immediately; after release with run=0 the block stays IDLE.
